// File: rtl/mrd_pkg.sv
// mrd_pkg: shared constants and types for the Mixed Radix DFT factoriser.
//   RDX4/RDX2/RDX5/RDX3/RDX1 : radix values in factor-priority order
//   NO_RDX2                  : stage_of_rdx2 value meaning "no radix-2 stage"
//   mrd_state_e              : factoriser FSM state
//   mrd_nf_arr_t/mrd_pts_arr_t : packed per-stage arrays at default sizes
package mrd_pkg;

  localparam int unsigned DW_DEF         = 12;
  localparam int unsigned MAX_STAGES_DEF = 6;
  localparam int unsigned FW_DEF         = 3;

  localparam int unsigned RDX4 = 4;
  localparam int unsigned RDX2 = 2;
  localparam int unsigned RDX5 = 5;
  localparam int unsigned RDX3 = 3;
  localparam int unsigned RDX1 = 1;

  localparam logic [FW_DEF-1:0] NO_RDX2 = '1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mrd_state_e;

  typedef logic [0:MAX_STAGES_DEF-1][FW_DEF-1:0] mrd_nf_arr_t;
  typedef logic [0:MAX_STAGES_DEF-1][DW_DEF-1:0] mrd_pts_arr_t;

endpackage

// File: rtl/mrd_factor_pick.sv
// mrd_factor_pick: combinational choice of the next radix for one stage.
//   n_iter_i     : remaining (not yet factored) point count
//   n_i          : full DFT size
//   f_o          : chosen radix, priority 4,2,5,3, else 1 (also 1 when n_iter_i==0)
//   n_iter_div_o : n_iter_i / f_o
//   n_div_o      : n_i / f_o
// Only constant divisors appear, so no general divider is built.
module mrd_factor_pick
  import mrd_pkg::*;
#(
  parameter int unsigned DW = 12,
  parameter int unsigned FW = 3
) (
  input  logic [DW-1:0] n_iter_i,
  input  logic [DW-1:0] n_i,
  output logic [FW-1:0] f_o,
  output logic [DW-1:0] n_iter_div_o,
  output logic [DW-1:0] n_div_o
);

  always_comb begin
    f_o          = FW'(RDX1);
    n_iter_div_o = n_iter_i;
    n_div_o      = n_i;
    if (n_iter_i == '0) begin
      f_o = FW'(RDX1);
    end else if (n_iter_i[1:0] == 2'b00) begin
      f_o          = FW'(RDX4);
      n_iter_div_o = n_iter_i >> 2;
      n_div_o      = n_i >> 2;
    end else if (n_iter_i[0] == 1'b0) begin
      f_o          = FW'(RDX2);
      n_iter_div_o = n_iter_i >> 1;
      n_div_o      = n_i >> 1;
    end else if ((n_iter_i % DW'(RDX5)) == '0) begin
      f_o          = FW'(RDX5);
      n_iter_div_o = n_iter_i / DW'(RDX5);
      n_div_o      = n_i / DW'(RDX5);
    end else if ((n_iter_i % DW'(RDX3)) == '0) begin
      f_o          = FW'(RDX3);
      n_iter_div_o = n_iter_i / DW'(RDX3);
      n_div_o      = n_i / DW'(RDX3);
    end
  end

endmodule

// File: rtl/mrd_factor_gen.sv
// mrd_factor_gen: run-time factoriser producing Mixed Radix DFT stage parameters.
// On sink_sop the size dftpts is factored one stage per cycle over MAX_STAGES
// cycles; the complete parameter set is committed atomically with a done pulse.
//   clk, rst_n     : clock, asynchronous active-low reset
//   sink_sop       : start pulse (also aborts/restarts a run in progress)
//   dftpts         : DFT size sampled on sink_sop
//   busy           : factorisation in progress
//   done           : one-cycle pulse when a new set is committed
//   params_vld     : a set has been committed since reset
//   err            : last committed size not fully factorable (only with
//                    MRD_FACTOR_CHK_EN defined; otherwise tied 0)
//   Nf, dftpts_div_Nf, twdl_demontr : per-stage radix, N/Nf, twiddle denominator
//   NumOfFactors   : number of stages with Nf != 1
//   stage_of_rdx2  : index of the radix-2 stage, all-ones if none
// Optional feature macro: MRD_FACTOR_CHK_EN
module mrd_factor_gen
  import mrd_pkg::*;
#(
  parameter int unsigned DW         = 12,
  parameter int unsigned MAX_STAGES = 6,
  parameter int unsigned FW         = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sink_sop,
  input  logic [DW-1:0]                       dftpts,
  output logic                                busy,
  output logic                                done,
  output logic                                params_vld,
  output logic                                err,
  output logic [0:MAX_STAGES-1][FW-1:0]       Nf,
  output logic [0:MAX_STAGES-1][DW-1:0]       dftpts_div_Nf,
  output logic [0:MAX_STAGES-1][DW-1:0]       twdl_demontr,
  output logic [FW-1:0]                       NumOfFactors,
  output logic [FW-1:0]                       stage_of_rdx2
);

  mrd_state_e                    state_q, state_d;
  logic [FW-1:0]                 cnt_q, cnt_d;
  logic [DW-1:0]                 n_q, n_d;
  logic [DW-1:0]                 niter_q, niter_d;

  // working set, built stage by stage
  logic [0:MAX_STAGES-1][FW-1:0] w_nf_q, w_nf_d;
  logic [0:MAX_STAGES-1][DW-1:0] w_div_q, w_div_d;
  logic [0:MAX_STAGES-1][DW-1:0] w_twdl_q, w_twdl_d;
  logic [FW-1:0]                 w_nof_q, w_nof_d;
  logic [FW-1:0]                 w_r2_q, w_r2_d;

  // committed set
  logic [0:MAX_STAGES-1][FW-1:0] nf_q, nf_d;
  logic [0:MAX_STAGES-1][DW-1:0] div_q, div_d;
  logic [0:MAX_STAGES-1][DW-1:0] twdl_q, twdl_d;
  logic [FW-1:0]                 nof_q, nof_d;
  logic [FW-1:0]                 r2_q, r2_d;
  logic                          done_q, done_d;
  logic                          vld_q, vld_d;

  logic [FW-1:0]                 pick_f;
  logic [DW-1:0]                 pick_niter_div;
  logic [DW-1:0]                 pick_n_div;

  mrd_factor_pick #(
    .DW (DW),
    .FW (FW)
  ) u_pick (
    .n_iter_i     (niter_q),
    .n_i          (n_q),
    .f_o          (pick_f),
    .n_iter_div_o (pick_niter_div),
    .n_div_o      (pick_n_div)
  );

`ifdef MRD_FACTOR_CHK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    niter_d  = niter_q;
    w_nf_d   = w_nf_q;
    w_div_d  = w_div_q;
    w_twdl_d = w_twdl_q;
    w_nof_d  = w_nof_q;
    w_r2_d   = w_r2_q;
    nf_d     = nf_q;
    div_d    = div_q;
    twdl_d   = twdl_q;
    nof_d    = nof_q;
    r2_d     = r2_q;
    done_d   = 1'b0;
    vld_d    = vld_q;
`ifdef MRD_FACTOR_CHK_EN
    err_d    = err_q;
`endif

    if (sink_sop) begin
      // start, or abort-and-restart; committed outputs are left untouched
      state_d = ST_RUN;
      cnt_d   = '0;
      n_d     = dftpts;
      niter_d = dftpts;
      for (int unsigned j = 0; j < MAX_STAGES; j++) begin
        w_nf_d[j]   = FW'(1);
        w_div_d[j]  = '0;
        w_twdl_d[j] = '0;
      end
      w_nof_d = '0;
      w_r2_d  = '1;
    end else if (state_q == ST_RUN) begin
      w_nf_d[cnt_q]   = pick_f;
      w_div_d[cnt_q]  = pick_n_div;
      w_twdl_d[cnt_q] = niter_q;
      niter_d         = pick_niter_div;
      if (pick_f != FW'(RDX1)) w_nof_d = w_nof_q + FW'(1);
      if (pick_f == FW'(RDX2)) w_r2_d  = cnt_q;

      if (cnt_q == FW'(MAX_STAGES - 1)) begin
        // commit includes this final stage's results
        nf_d    = w_nf_d;
        div_d   = w_div_d;
        twdl_d  = w_twdl_d;
        nof_d   = w_nof_d;
        r2_d    = w_r2_d;
        done_d  = 1'b1;
        vld_d   = 1'b1;
        state_d = ST_IDLE;
`ifdef MRD_FACTOR_CHK_EN
        err_d   = (pick_niter_div != DW'(1)) || (n_q == '0);
`endif
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      niter_q  <= '0;
      for (int unsigned j = 0; j < MAX_STAGES; j++) begin
        w_nf_q[j] <= FW'(1);
        nf_q[j]   <= FW'(1);
      end
      w_div_q  <= '0;
      w_twdl_q <= '0;
      w_nof_q  <= '0;
      w_r2_q   <= '1;
      div_q    <= '0;
      twdl_q   <= '0;
      nof_q    <= '0;
      r2_q     <= '1;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      niter_q  <= niter_d;
      w_nf_q   <= w_nf_d;
      w_div_q  <= w_div_d;
      w_twdl_q <= w_twdl_d;
      w_nof_q  <= w_nof_d;
      w_r2_q   <= w_r2_d;
      nf_q     <= nf_d;
      div_q    <= div_d;
      twdl_q   <= twdl_d;
      nof_q    <= nof_d;
      r2_q     <= r2_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
    end
  end

`ifdef MRD_FACTOR_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy          = (state_q == ST_RUN);
  assign done          = done_q;
  assign params_vld    = vld_q;
  assign Nf            = nf_q;
  assign dftpts_div_Nf = div_q;
  assign twdl_demontr  = twdl_q;
  assign NumOfFactors  = nof_q;
  assign stage_of_rdx2 = r2_q;

endmodule

// File: tb/tb_mrd_factor_gen.sv
// tb_mrd_factor_gen: randomized and directed check of mrd_factor_gen against a
// behavioural factorisation model; timing, abort, reset-mid-run and hold checks.
module tb_mrd_factor_gen;
  import mrd_pkg::*;

  localparam int unsigned STAGES = MAX_STAGES_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sink_sop = 1'b0;
  logic [11:0]  dftpts = '0;
  logic         busy, done, params_vld, err;
  mrd_nf_arr_t  nf_o;
  mrd_pts_arr_t div_o, twdl_o;
  logic [2:0]   nof_o, r2_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // expected committed state
  mrd_nf_arr_t  exp_nf;
  mrd_pts_arr_t exp_div, exp_twdl;
  int unsigned  exp_nof, exp_r2, exp_err, exp_vld;

  always #5 clk = ~clk;

  mrd_factor_gen #(
    .DW         (12),
    .MAX_STAGES (STAGES),
    .FW         (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sink_sop      (sink_sop),
    .dftpts        (dftpts),
    .busy          (busy),
    .done          (done),
    .params_vld    (params_vld),
    .err           (err),
    .Nf            (nf_o),
    .dftpts_div_Nf (div_o),
    .twdl_demontr  (twdl_o),
    .NumOfFactors  (nof_o),
    .stage_of_rdx2 (r2_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Repeatedly strip the highest-priority radix that divides the remainder.
  function automatic void ref_factor(input int unsigned n,
                                     output mrd_nf_arr_t nf, output mrd_pts_arr_t dv,
                                     output mrd_pts_arr_t tw, output int unsigned nof,
                                     output int unsigned r2, output int unsigned er);
    int unsigned rem;
    int unsigned radices[4];
    int unsigned f;
    radices = '{4, 2, 5, 3};
    rem = n;
    nof = 0;
    r2  = 7;
    for (int unsigned j = 0; j < STAGES; j++) begin
      f = 1;
      if (rem != 0) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (f == 1 && rem % radices[k] == 0) f = radices[k];
        end
      end
      nf[j] = 3'(f);
      dv[j] = 12'(n / f);
      tw[j] = 12'(rem);
      if (f != 1) nof++;
      if (f == 2) r2 = j;
      rem = rem / f;
    end
`ifdef MRD_FACTOR_CHK_EN
    er = (rem != 1 || n == 0) ? 1 : 0;
`else
    er = 0;
`endif
  endfunction

  task automatic set_reset_expect();
    for (int unsigned j = 0; j < STAGES; j++) begin
      exp_nf[j]   = 3'd1;
      exp_div[j]  = '0;
      exp_twdl[j] = '0;
    end
    exp_nof = 0;
    exp_r2  = 7;
    exp_err = 0;
    exp_vld = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_nf"},   nf_o,       exp_nf);
    check({tag, "_div"},  div_o,      exp_div);
    check({tag, "_twdl"}, twdl_o,     exp_twdl);
    check({tag, "_nof"},  nof_o,      exp_nof);
    check({tag, "_r2"},   r2_o,       exp_r2);
    check({tag, "_err"},  err,        exp_err);
    check({tag, "_vld"},  params_vld, exp_vld);
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled sink_sop.
  task automatic start(input int unsigned n);
    dftpts   = 12'(n);
    sink_sop = 1'b1;
    @(posedge clk);
    #1;
    sink_sop = 1'b0;
    check("busy_after_sop", busy, 1);
  endtask

  // done must appear in cycle T+STAGES+1, i.e. STAGES edges after the sampling
  // edge T; earlier cycles must hold the previous committed set.
  task automatic wait_done(input int unsigned n);
    mrd_nf_arr_t  nf;
    mrd_pts_arr_t dv, tw;
    int unsigned  nof, r2, er;
    bit           seen;
    seen = 0;
    for (int unsigned k = 1; k <= STAGES + 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        check("done_latency", k, STAGES);
        check("busy_in_done", busy, 0);
        ref_factor(n, nf, dv, tw, nof, r2, er);
        exp_nf = nf; exp_div = dv; exp_twdl = tw;
        exp_nof = nof; exp_r2 = r2; exp_err = er; exp_vld = 1;
        check_outputs($sformatf("n%0d", n));
      end else begin
        check("hold_nf", nf_o, exp_nf);
        check("hold_twdl", twdl_o, exp_twdl);
        check("busy_running", busy, 1);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run(input int unsigned n);
    start(n);
    wait_done(n);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int unsigned n;
    set_reset_expect();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(1200);
    run(1536);
    run(12);
    run(14);

    // sop in the done cycle starts a new run normally
    start(1536);
    wait_done(1536);
    start(12);
    wait_done(12);

    // abort: sop(1200), then sop(12) three edges later; only one done
    run(1536);
    start(1200);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
      check("abort_hold_nf", nf_o, exp_nf);
    end
    start(12);
    wait_done(12);
    repeat (8) begin
      @(posedge clk);
      #1;
      check("abort_no_extra_done", done, 0);
    end

    // reset mid-run
    start(1200);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    set_reset_expect();
    check("rst_mid_busy", busy, 0);
    check_outputs("rst_mid");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_done", done, 0);
    end
    run(1200);

    // random sizes: half arbitrary, half smooth products of 2,3,5
    for (int unsigned i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        n = $urandom_range(0, 4095);
      end else begin
        n = 1;
        for (int unsigned k = 0; k < 8; k++) begin
          int unsigned r;
          r = (($urandom % 3) == 0) ? 2 : ((($urandom % 2) == 0) ? 3 : 5);
          if (n * r <= 4095) n = n * r;
        end
      end
      run(n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
